// File: rtl/seq_pkg.sv
// Shared definitions for the 1101 pattern source and its detector:
// FSM state encoding and the default test pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] PAT_DEFAULT = 4'b1101;

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-load, MSB-first shift register. Load wins over shift, and zeros
// are shifted in at the LSB end.
module seq_piso_shreg #(
  parameter int W = 4
) (
  input  logic         mclk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  // Load or shift the pattern register.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= din_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end else begin
      sr_q <= sr_q;
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first
// for a number of frames, with a programmable idle gap between frames.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int REP_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [REP_W-1:0] repeat_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             dout_o,
  output logic             dout_vld_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int              BW       = $clog2(PAT_W);
  localparam logic [BW-1:0]   BIT_LAST = BW'(PAT_W - 1);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [REP_W-1:0]   frm_cnt_q, frm_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               dout_q, vld_q, busy_q, done_q;

  logic               start_ok_s;
  logic               frame_end_s;
  logic               last_frame_s;
  logic               new_frame_s;
  logic               shift_s;
  logic [PAT_W-1:0]   src_pat_s;
  logic [PAT_W-1:0]   sr_din_s;
  logic               sr_msb_s;
  logic               dout_d;

  assign start_ok_s   = (state_q == ST_IDLE) && start_i;
  assign frame_end_s  = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
  assign last_frame_s = (frm_cnt_q == REP_W'(1));

  // State register.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (repeat_i != '0) ? ST_SHIFT : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q != '0) begin
          state_d = ST_SHIFT;
        end else if (last_frame_s) begin
          state_d = ST_DONE;
        end else if (gap_q != '0) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A frame begins whenever SHIFT is entered, or re-entered after bit 0.
  assign new_frame_s = (state_d == ST_SHIFT) &&
                       ((state_q != ST_SHIFT) || (bit_cnt_q == '0));
  assign shift_s     = (state_q == ST_SHIFT) && (bit_cnt_q != '0);
  assign src_pat_s   = (state_q == ST_IDLE) ? pattern_i : pat_q;
  // The MSB goes straight to dout; the register keeps the remaining bits.
  assign sr_din_s    = {src_pat_s[PAT_W-2:0], 1'b0};

  // Counter and capture next-state values.
  always_comb begin
    pat_d     = pat_q;
    gap_d     = gap_q;
    frm_cnt_d = frm_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (start_ok_s) begin
      pat_d     = pattern_i;
      gap_d     = gap_i;
      frm_cnt_d = repeat_i;
    end else if (frame_end_s) begin
      frm_cnt_d = frm_cnt_q - REP_W'(1);
    end else begin
      frm_cnt_d = frm_cnt_q;
    end
    if (new_frame_s) begin
      bit_cnt_d = BIT_LAST;
    end else if (shift_s) begin
      bit_cnt_d = bit_cnt_q - BW'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    if ((state_q == ST_SHIFT) && (state_d == ST_GAP)) begin
      gap_cnt_d = gap_q - GAP_W'(1);
    end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end else begin
      gap_cnt_d = gap_cnt_q;
    end
  end

  // Counter and capture registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= '0;
      gap_q     <= '0;
      frm_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      pat_q     <= pat_d;
      gap_q     <= gap_d;
      frm_cnt_q <= frm_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  seq_piso_shreg #(.W(PAT_W)) u_shreg (
    .mclk    (mclk),
    .rst_n   (rst_n),
    .load_i  (new_frame_s),
    .shift_i (shift_s),
    .din_i   (sr_din_s),
    .msb_o   (sr_msb_s)
  );

  // Bit that will be on the line during the next state.
  always_comb begin
    if (new_frame_s) begin
      dout_d = src_pat_s[PAT_W-1];
    end else if (state_d == ST_SHIFT) begin
      dout_d = sr_msb_s;
    end else begin
      dout_d = 1'b0;
    end
  end

  // Registered outputs, decoded from the next state.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= (state_d == ST_SHIFT);
      busy_q <= (state_d == ST_SHIFT) || (state_d == ST_GAP);
      done_q <= (state_d == ST_DONE);
    end
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed and random transfers
// compared cycle by cycle against a frame/gap stream model.
module tb_seq_pattern_gen;
  import seq_pkg::*;

  localparam int PAT_W = 4;
  localparam int REP_W = 8;
  localparam int GAP_W = 4;

  logic             mclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [PAT_W-1:0] pattern_i = '0;
  logic [REP_W-1:0] repeat_i = '0;
  logic [GAP_W-1:0] gap_i = '0;
  logic             dout_o, dout_vld_o, busy_o, done_o;

  int n_checks = 0;
  int n_errors = 0;
  int det_cnt  = 0;

  seq_pattern_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .pattern_i  (pattern_i),
    .repeat_i   (repeat_i),
    .gap_i      (gap_i),
    .dout_o     (dout_o),
    .dout_vld_o (dout_vld_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observed vector: {dout, vld, busy, done}
  function automatic logic [3:0] obs_vec();
    return {dout_o, dout_vld_o, busy_o, done_o};
  endfunction

  // Starts a transfer (caller sits just after a rising edge with the DUT idle)
  // and checks every output cycle until one idle cycle after done.
  task automatic run_xfer(input logic [PAT_W-1:0] pat, input logic [REP_W-1:0] rep,
                          input logic [GAP_W-1:0] gap, input int abort_at, input bit disturb);
    logic [3:0] exp_q[$];
    logic [3:0] sh;
    int         nbits;
    sh    = 4'b0000;
    nbits = 0;
    for (int f = 0; f < int'(rep); f++) begin
      for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({pat[i], 3'b110});
      if (f < int'(rep) - 1)
        for (int g = 0; g < int'(gap); g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
    det_cnt   = 0;
    start_i   = 1'b1;
    pattern_i = pat;
    repeat_i  = rep;
    gap_i     = gap;
    @(posedge mclk); #1;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (j > 0) begin
        @(posedge mclk); #1;
      end
      check($sformatf("p%h r%0d g%0d cyc%0d", pat, rep, gap, j), {28'd0, obs_vec()}, {28'd0, exp_q[j]});
      if (dout_vld_o) begin
        sh = {sh[2:0], dout_o};
        nbits++;
        if (nbits >= 4 && sh == 4'b1101) det_cnt++;
      end
      if (j == abort_at) begin
        start_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async", {28'd0, obs_vec()}, 32'd0);
        @(posedge mclk); #1;
        check("rst_hold", {28'd0, obs_vec()}, 32'd0);
        rst_n = 1'b1;
        @(posedge mclk); #1;
        check("post_rst_idle", {28'd0, obs_vec()}, 32'd0);
        return;
      end
      if (disturb && (j < exp_q.size() - 1) && ($urandom_range(0, 2) == 0)) begin
        start_i   = 1'b1;
        pattern_i = PAT_W'($urandom);
        repeat_i  = REP_W'($urandom_range(1, 3));
        gap_i     = GAP_W'($urandom);
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
  endtask

  initial begin
    int abort_at;
    logic [REP_W-1:0] rep;
    logic [GAP_W-1:0] gap;
    rst_n = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    check("reset_state", {28'd0, obs_vec()}, 32'd0);
    rst_n = 1'b1;
    @(posedge mclk); #1;
    check("idle_after_reset", {28'd0, obs_vec()}, 32'd0);

    run_xfer(PAT_DEFAULT, 8'd1, 4'd0, -1, 1'b0);
    run_xfer(PAT_DEFAULT, 8'd3, 4'd0, -1, 1'b0);
    check("det_cnt", det_cnt, 32'd3);
    run_xfer(PAT_DEFAULT, 8'd2, 4'd3, -1, 1'b0);
    run_xfer(PAT_DEFAULT, 8'd0, 4'd5, -1, 1'b0);
    run_xfer(PAT_DEFAULT, 8'd2, 4'd1, -1, 1'b1);
    run_xfer(PAT_DEFAULT, 8'd2, 4'd0, 1, 1'b0);
    run_xfer(PAT_DEFAULT, 8'd1, 4'd0, -1, 1'b0);
    run_xfer(4'b1001, 8'd2, 4'd15, -1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      rep      = REP_W'($urandom_range(0, 4));
      gap      = ($urandom_range(0, 7) == 0) ? 4'd15 : GAP_W'($urandom_range(0, 4));
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_xfer(PAT_W'($urandom), rep, gap, abort_at, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
